// File: rtl/traffic_ctrl_timed.sv
// Tick-timed multi-approach traffic signal controller with demand skipping
// and emergency pre-emption; outputs decode from registered state only.
module traffic_ctrl_timed #(
    parameter int NUM_DIR      = 4,
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter bit SKIP_EN      = 1'b1,
    localparam int DIR_W       = $clog2(NUM_DIR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_en,
    input  logic [NUM_DIR-1:0]     req,
    input  logic                   emerg,
    input  logic [DIR_W-1:0]       emerg_dir,
    output logic [3*NUM_DIR-1:0]   lamps,
    output logic [DIR_W-1:0]       active_dir,
    output logic [1:0]             phase
);

    typedef enum logic [1:0] {
        S_ALL_RED = 2'b00,
        S_GREEN   = 2'b01,
        S_YELLOW  = 2'b10,
        S_EMERG   = 2'b11
    } state_t;

    localparam logic [2:0] L_RED = 3'b001;
    localparam logic [2:0] L_GRN = 3'b010;
    localparam logic [2:0] L_YEL = 3'b100;

    localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_TICKS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [DIR_W-1:0]   active_q, active_d;
    logic [DIR_W-1:0]   next_dir;
    logic               emerg_ok;
    logic               expired;

    // An out-of-range emergency approach is ignored entirely.
    assign emerg_ok = emerg &&
        ({1'b0, emerg_dir} < (DIR_W+1)'(NUM_DIR));
    assign expired  = tick_en && (timer_q == '0);

    always_comb begin
        int  j;
        logic found;
        j        = 0;
        found    = 1'b0;
        next_dir = DIR_W'((int'(active_q) + 1) % NUM_DIR);
        if (SKIP_EN) begin
            for (int i = 1; i <= NUM_DIR; i++) begin
                j = (int'(active_q) + i) % NUM_DIR;
                if (!found && req[j]) begin
                    next_dir = DIR_W'(j);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_ALL_RED;
            timer_q  <= T_ALLRED;
            active_q <= DIR_W'(NUM_DIR - 1);
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        active_d = active_q;
        unique case (state_q)
            S_ALL_RED: begin
                if (expired) begin
                    timer_d = T_GREEN;
                    if (emerg_ok) begin
                        state_d  = S_EMERG;
                        active_d = emerg_dir;
                    end else begin
                        state_d  = S_GREEN;
                        active_d = next_dir;
                    end
                end else if (tick_en) begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GREEN: begin
                if (emerg_ok && emerg_dir == active_q) begin
                    state_d = S_EMERG;
                end else if (tick_en && (emerg_ok || timer_q == '0)) begin
                    state_d = S_YELLOW;
                    timer_d = T_YELLOW;
                end else if (tick_en) begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_YELLOW: begin
                if (expired) begin
                    state_d = S_ALL_RED;
                    timer_d = T_ALLRED;
                end else if (tick_en) begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_EMERG: begin
                if (!emerg_ok) begin
                    state_d = S_GREEN;
                    timer_d = T_GREEN;
                end
            end
            default: begin
                state_d = S_ALL_RED;
                timer_d = T_ALLRED;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_DIR; i++) begin
            lamps[3*i +: 3] = L_RED;
            if (state_q != S_ALL_RED && DIR_W'(i) == active_q)
                lamps[3*i +: 3] = (state_q == S_YELLOW) ? L_YEL : L_GRN;
        end
    end

    assign active_dir = active_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// Directed self-checking bench for traffic_ctrl_timed (4-way skip, 4-way
// strict rotation, and a 5-way instance for the out-of-range emergency case).
module tb_traffic_ctrl_timed;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_en;
    logic [3:0]  req;
    logic        emerg;
    logic [1:0]  emerg_dir;
    logic [2:0]  ed5;
    logic [11:0] lamps, ns_lamps;
    logic [14:0] f_lamps;
    logic [1:0]  active_dir, ns_active;
    logic [2:0]  f_active;
    logic [1:0]  phase, ns_phase, f_phase;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    traffic_ctrl_timed #(
        .NUM_DIR(4), .CNT_W(8), .GREEN_TICKS(3), .YELLOW_TICKS(2),
        .ALLRED_TICKS(1), .SKIP_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .req(req),
        .emerg(emerg), .emerg_dir(emerg_dir), .lamps(lamps),
        .active_dir(active_dir), .phase(phase)
    );

    traffic_ctrl_timed #(
        .NUM_DIR(4), .CNT_W(8), .GREEN_TICKS(3), .YELLOW_TICKS(2),
        .ALLRED_TICKS(1), .SKIP_EN(1'b0)
    ) u_noskip (
        .clk(clk), .rst(rst), .tick_en(tick_en), .req(req),
        .emerg(emerg), .emerg_dir(emerg_dir), .lamps(ns_lamps),
        .active_dir(ns_active), .phase(ns_phase)
    );

    traffic_ctrl_timed #(
        .NUM_DIR(5), .CNT_W(8), .GREEN_TICKS(3), .YELLOW_TICKS(2),
        .ALLRED_TICKS(1), .SKIP_EN(1'b1)
    ) u_five (
        .clk(clk), .rst(rst), .tick_en(tick_en), .req({1'b1, req}),
        .emerg(emerg), .emerg_dir(ed5), .lamps(f_lamps),
        .active_dir(f_active), .phase(f_phase)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        tick_en   = 1'b1;
        emerg     = 1'b0;
        emerg_dir = 2'd0;
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pos;
        int ex_ph;
        ed5 = 3'd5;
        req = 4'b1111;

        // 1: full rotation
        do_reset();
        chk("rst_lamps", lamps, 12'h249);
        chk("rst_phase", phase, 0);
        chk("rst_dir", active_dir, 3);
        for (int k = 1; k <= 24; k++) begin
            edge1();
            pos   = (k - 1) % 6;
            ex_ph = (pos < 3) ? 1 : ((pos < 5) ? 2 : 0);
            chk($sformatf("s1_phase_%0d", k), phase, ex_ph);
            chk($sformatf("s1_dir_%0d", k), active_dir, (k - 1) / 6);
            if (k == 1) chk("s1_l_g0", lamps, 12'h24A);
            if (k == 4) chk("s1_l_y0", lamps, 12'h24C);
            if (k == 6) chk("s1_l_ar", lamps, 12'h249);
            if (k == 7) chk("s1_l_g1", lamps, 12'h251);
        end
        edge1();
        chk("s1_wrap_dir", active_dir, 0);
        chk("s1_wrap_lamps", lamps, 12'h24A);

        // 2: demand skipping vs strict rotation
        req = 4'b0101;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            edge1();
            chk($sformatf("s2_d1_%0d", k), lamps[5:3], 1);
            chk($sformatf("s2_d3_%0d", k), lamps[11:9], 1);
            if (k == 1)  chk("s2_g0", active_dir, 0);
            if (k == 7)  chk("s2_g2", active_dir, 2);
            if (k == 7)  chk("s2_g2_ph", phase, 1);
            if (k == 13) chk("s2_g0b", active_dir, 0);
            if (k == 7)  chk("s2_ns_g1", ns_active, 1);
            if (k == 13) chk("s2_ns_g2", ns_active, 2);
            if (k == 19) chk("s2_ns_g3", ns_active, 3);
            if (k == 19) chk("s2_ns_ph", ns_phase, 1);
        end

        // 3: sparse tick_en
        req = 4'b1111;
        do_reset();
        for (int p = 1; p <= 4; p++) begin
            for (int j = 0; j < 4; j++) begin
                tick_en = (j == 0);
                edge1();
                chk($sformatf("s3_ph_%0d_%0d", p, j), phase,
                    (p <= 3) ? 1 : 2);
                chk($sformatf("s3_tm_%0d_%0d", p, j), dut.timer_q,
                    (p <= 3) ? 3 - p : 1);
            end
        end
        tick_en = 1'b1;

        // 4: pre-emption of another approach
        do_reset();
        edge1();
        chk("s4_g0", lamps, 12'h24A);
        emerg     = 1'b1;
        emerg_dir = 2'd2;
        edge1();
        chk("s4_y0_a", phase, 2);
        chk("s4_y0_l", lamps, 12'h24C);
        edge1();
        chk("s4_y0_b", phase, 2);
        edge1();
        chk("s4_ar", phase, 0);
        for (int k = 0; k < 10; k++) begin
            edge1();
            chk($sformatf("s4_hold_%0d", k), phase, 3);
            chk($sformatf("s4_hl_%0d", k), lamps, 12'h289);
        end
        emerg = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            edge1();
            ex_ph = (k <= 3) ? 1 : ((k <= 5) ? 2 : ((k == 6) ? 0 : 1));
            chk($sformatf("s4_post_ph_%0d", k), phase, ex_ph);
            chk($sformatf("s4_post_d_%0d", k), active_dir,
                (k == 7) ? 3 : 2);
        end

        // 5: emergency on the current green, and out-of-range direction
        do_reset();
        repeat (7) edge1();
        chk("s5_g1", lamps, 12'h251);
        emerg     = 1'b1;
        emerg_dir = 2'd1;
        edge1();
        chk("s5_hold_ph", phase, 3);
        chk("s5_hold_l", lamps, 12'h251);
        chk("s5_hold_d", active_dir, 1);
        chk("s5_f_green", f_phase, 1);
        emerg_dir = 2'd3;
        edge1();
        chk("s5_ign_d", active_dir, 1);
        chk("s5_ign_l", lamps, 12'h251);
        edge1();
        chk("s5_f_yel", f_phase, 2);
        chk("s5_f_dir", f_active, 1);
        emerg = 1'b0;

        // 6: asynchronous reset mid-yellow
        do_reset();
        repeat (4) edge1();
        chk("s6_yel", phase, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_l", lamps, 12'h249);
        chk("s6_async_ph", phase, 0);
        chk("s6_async_d", active_dir, 3);
        @(negedge clk);
        rst = 1'b0;
        edge1();
        chk("s6_rec_g0", lamps, 12'h24A);
        repeat (6) edge1();
        chk("s6_rec_g1", active_dir, 1);
        chk("s6_rec_ph", phase, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
